// File: rtl/spi_cmd_dispatcher_pkg.sv
// Shared definitions for the keyboard/lightbox SPI command dispatcher:
// command numbers, soft-reset key and FSM state encodings.
package spi_cmd_dispatcher_pkg;

    // Command numbers carried in the 3-bit command address field
    localparam logic [2:0] CMD_NOP        = 3'd0;
    localparam logic [2:0] CMD_VERSION    = 3'd1;
    localparam logic [2:0] CMD_LED_LO     = 3'd2;
    localparam logic [2:0] CMD_LED_HI     = 3'd3;
    localparam logic [2:0] CMD_BLINK_CFG  = 3'd4;
    localparam logic [2:0] CMD_KEY_READ   = 3'd5;
    localparam logic [2:0] CMD_STATUS     = 3'd6;
    localparam logic [2:0] CMD_SOFT_RESET = 3'd7;

    // Data byte that must accompany SOFT_RESET for it to take effect
    localparam logic [7:0] SOFT_RST_KEY   = 8'hA5;

    // Command sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CAPTURE   = 3'd1,
        ST_EXEC      = 3'd2,
        ST_WAIT_IDLE = 3'd3,
        ST_LOAD      = 3'd4
    } state_t;

endpackage

// File: rtl/blink_timer.sv
// Blink timebase: a free-running prescaler produces a tick every PRESCALE
// clocks; a tick counter toggles the blink phase every 'period' ticks.
// A period of zero freezes the phase. 'restart' re-aligns everything with
// phase = 1.
module blink_timer #(
    parameter int PRESCALE  = 1000,
    parameter int PER_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PER_WIDTH-1:0] period,
    input  logic                 restart,
    output logic                 phase
);

    localparam int PW = $clog2(PRESCALE);

    logic [PW-1:0]        r_presc;
    logic [PER_WIDTH-1:0] r_tick_cnt;
    logic                 r_phase;
    logic                 w_tick;

    assign w_tick = (r_presc == PW'(PRESCALE - 1));
    assign phase  = r_phase;

    // Prescaler, period counter and phase toggle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc    <= '0;
            r_tick_cnt <= '0;
            r_phase    <= 1'b1;
        end else if (restart) begin
            r_presc    <= '0;
            r_tick_cnt <= '0;
            r_phase    <= 1'b1;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (period == '0) begin
                r_tick_cnt <= '0;
            end else if (w_tick) begin
                if (r_tick_cnt >= period - PER_WIDTH'(1)) begin
                    r_tick_cnt <= '0;
                    r_phase    <= ~r_phase;
                end else begin
                    r_tick_cnt <= r_tick_cnt + PER_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/spi_cmd_dispatcher.sv
// Command dispatcher for the keyboard/lightbox SPI slave. Brings the
// slave's command strobe into the clk domain, executes the captured
// command on the LED / blink / key-latch resources and loads the reply
// byte for the next SPI transaction once chip select is released.
module spi_cmd_dispatcher
    import spi_cmd_dispatcher_pkg::*;
#(
    parameter int                     COMM_WIDTH     = 8,
    parameter int                     ADR_WIDTH      = 3,
    parameter int                     REPLY_WIDTH    = 8,
    parameter int                     LED_NUM        = 16,
    parameter int                     KEY_NUM        = 8,
    parameter logic [REPLY_WIDTH-1:0] CPLD_VERSION   = 8'h11,
    parameter int                     BLINK_PRESCALE = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   comm_ready,
    input  logic [ADR_WIDTH-1:0]   comm_adr,
    input  logic [COMM_WIDTH-1:0]  comm_data,
    input  logic                   spi_sel,
    input  logic [KEY_NUM-1:0]     key_state,
    output logic [REPLY_WIDTH-1:0] reply_data,
    output logic [LED_NUM-1:0]     led_out,
    output logic                   soft_rst
);

    // Synchronisers (two flops) plus one history flop for edge detection
    logic [1:0]          r_cr_sync;
    logic                r_cr_prev;
    logic [1:0]          r_sel_sync;
    logic [KEY_NUM-1:0]  r_key_sync0;
    logic [KEY_NUM-1:0]  r_key_sync1;
    logic [KEY_NUM-1:0]  r_key_prev;

    state_t              r_state;
    state_t              w_state_next;

    logic [ADR_WIDTH-1:0]   r_adr;
    logic [COMM_WIDTH-1:0]  r_data;
    logic [ADR_WIDTH-1:0]   r_last_adr;
    logic [LED_NUM-1:0]     r_led_reg;
    logic [COMM_WIDTH-1:0]  r_blink_per;
    logic [KEY_NUM-1:0]     r_key_latch;
    logic                   r_overrun;
    logic                   r_soft_rst;
    logic [REPLY_WIDTH-1:0] r_reply_data;

    logic                   w_cmd_evt;
    logic                   w_bus_idle;
    logic [KEY_NUM-1:0]     w_key_rise;
    logic                   w_exec;
    logic                   w_load;
    logic                   w_soft_ok;
    logic                   w_restart;
    logic                   w_phase;
    logic                   w_blink_on;
    logic [KEY_NUM-1:0]     w_key_clear;
    logic [REPLY_WIDTH-1:0] w_reply_val;

    assign w_cmd_evt  = r_cr_sync[1] & ~r_cr_prev;
    assign w_bus_idle = r_sel_sync[1];
    assign w_key_rise = r_key_sync1 & ~r_key_prev;
    assign w_blink_on = (r_blink_per != '0);

    // A SOFT_RESET only counts when it carries the key byte
    assign w_soft_ok  = w_exec && (r_adr == CMD_SOFT_RESET) && (r_data == SOFT_RST_KEY);
    // Re-align the blink timebase whenever its period is rewritten
    assign w_restart  = (w_exec && (r_adr == CMD_BLINK_CFG)) || w_soft_ok;

    // Bits reported by a KEY_READ are cleared when its reply is loaded
    assign w_key_clear = (w_load && (r_adr == CMD_KEY_READ)) ? r_key_latch : '0;

    assign reply_data = r_reply_data;
    assign soft_rst   = r_soft_rst;
    assign led_out    = r_led_reg & (w_blink_on ? {LED_NUM{w_phase}} : {LED_NUM{1'b1}});

    // Input synchronisers and edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cr_sync   <= '0;
            r_cr_prev   <= 1'b0;
            r_sel_sync  <= 2'b11;
            r_key_sync0 <= '0;
            r_key_sync1 <= '0;
            r_key_prev  <= '0;
        end else begin
            r_cr_sync   <= {r_cr_sync[0], comm_ready};
            r_cr_prev   <= r_cr_sync[1];
            r_sel_sync  <= {r_sel_sync[0], spi_sel};
            r_key_sync0 <= key_state;
            r_key_sync1 <= r_key_sync0;
            r_key_prev  <= r_key_sync1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; the reply is only loaded while chip select is high,
    // so a bus that goes busy during LOAD sends the FSM back to wait
    always_comb begin
        w_state_next = r_state;
        w_exec       = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE:      if (w_cmd_evt) w_state_next = ST_CAPTURE;
            ST_CAPTURE:   w_state_next = ST_EXEC;
            ST_EXEC: begin
                w_exec       = 1'b1;
                w_state_next = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: if (w_bus_idle) w_state_next = ST_LOAD;
            ST_LOAD: begin
                if (w_bus_idle) begin
                    w_load       = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_WAIT_IDLE;
                end
            end
            default:      w_state_next = ST_IDLE;
        endcase
    end

    // Reply value for the command being completed
    always_comb begin
        w_reply_val = '0;
        case (r_adr)
            CMD_NOP:        w_reply_val = '0;
            CMD_VERSION:    w_reply_val = CPLD_VERSION;
            CMD_LED_LO,
            CMD_LED_HI,
            CMD_BLINK_CFG:  w_reply_val = REPLY_WIDTH'(r_data);
            CMD_KEY_READ:   w_reply_val = REPLY_WIDTH'(r_key_latch);
            CMD_STATUS:     w_reply_val = REPLY_WIDTH'({r_overrun, w_blink_on, w_phase, 2'b00, r_last_adr});
            CMD_SOFT_RESET: w_reply_val = REPLY_WIDTH'(r_data == SOFT_RST_KEY);
            default:        w_reply_val = '0;
        endcase
    end

    // Command capture, execution and reply load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_adr        <= '0;
            r_data       <= '0;
            r_last_adr   <= '0;
            r_led_reg    <= '0;
            r_blink_per  <= '0;
            r_soft_rst   <= 1'b0;
            r_reply_data <= '0;
        end else begin
            r_soft_rst <= w_soft_ok;
            if (r_state == ST_CAPTURE) begin
                r_adr  <= comm_adr;
                r_data <= comm_data;
            end
            if (w_exec) begin
                case (r_adr)
                    CMD_LED_LO:    r_led_reg[7:0]  <= r_data;
                    CMD_LED_HI:    r_led_reg[15:8] <= r_data;
                    CMD_BLINK_CFG: r_blink_per     <= r_data;
                    default:       ;
                endcase
            end
            if (w_soft_ok) begin
                r_led_reg   <= '0;
                r_blink_per <= '0;
            end
            if (w_load) begin
                r_reply_data <= w_reply_val;
                r_last_adr   <= r_adr;
            end
        end
    end

    // Key latch: a new press wins over a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_latch <= '0;
        end else begin
            r_key_latch <= (r_key_latch & ~w_key_clear & ~{KEY_NUM{w_soft_ok}}) | w_key_rise;
        end
    end

    // Sticky overrun: a command strobe arriving while busy is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= (w_cmd_evt && (r_state != ST_IDLE))
                       | (r_overrun & ~(w_load && (r_adr == CMD_STATUS)));
        end
    end

    blink_timer #(
        .PRESCALE  (BLINK_PRESCALE),
        .PER_WIDTH (COMM_WIDTH)
    ) u_blink_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .period  (r_blink_per),
        .restart (w_restart),
        .phase   (w_phase)
    );

endmodule

// File: tb/tb_spi_cmd_dispatcher.sv
// Bench for spi_cmd_dispatcher. Each transaction pushes the reply the host
// should read on the following chip-select fall; a monitor pops and
// compares on every falling spi_sel.
module tb_spi_cmd_dispatcher;
    import spi_cmd_dispatcher_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        comm_ready = 1'b0;
    logic [2:0]  comm_adr = '0;
    logic [7:0]  comm_data = '0;
    logic        spi_sel = 1'b1;
    logic [7:0]  key_state = '0;
    logic [7:0]  reply_data;
    logic [15:0] led_out;
    logic        soft_rst;

    int total = 0;
    int bad   = 0;
    int sr_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    spi_cmd_dispatcher #(
        .BLINK_PRESCALE (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .comm_ready (comm_ready),
        .comm_adr   (comm_adr),
        .comm_data  (comm_data),
        .spi_sel    (spi_sel),
        .key_state  (key_state),
        .reply_data (reply_data),
        .led_out    (led_out),
        .soft_rst   (soft_rst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // Scoreboard monitor: host samples the reply as chip select falls
    always @(negedge spi_sel) begin
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL reply_unexpected_txn: got %0h with no expectation queued", reply_data);
        end else begin
            mon_exp = exp_q.pop_front();
            chk("reply", {24'h0, reply_data}, {24'h0, mon_exp});
        end
    end

    // Width of every soft_rst pulse, measured in clocks
    always @(negedge clk) if (soft_rst === 1'b1) sr_cnt++;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [2:0] adr, input logic [7:0] data);
        comm_adr   = adr;
        comm_data  = data;
        comm_ready = 1'b1;
        tick(4);
        comm_ready = 1'b0;
        tick(2);
    endtask

    task automatic send(input logic [2:0] adr, input logic [7:0] data, input logic [7:0] exp);
        exp_q.push_back(exp);
        spi_sel = 1'b0;
        tick(3);
        pulse(adr, data);
        spi_sel = 1'b1;
        tick(10);
    endtask

    task automatic wait_exec(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dut.r_state == ST_EXEC) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        bit ok;
        int n;
        int sr_before;

        // 1: reset values
        tick(3);
        chk("rst_reply", {24'h0, reply_data}, 32'h0);
        chk("rst_led", {16'h0, led_out}, 32'h0);
        rst_n = 1'b1;
        tick(2);
        chk("post_rst_reply", {24'h0, reply_data}, 32'h0);
        chk("post_rst_led", {16'h0, led_out}, 32'h0);
        chk("post_rst_soft", {31'h0, soft_rst}, 32'h0);
        exp_q.push_back(8'h00);

        // 2: LED_LO then LED_HI; reply held until chip select rises
        send(CMD_LED_LO, 8'h3C, 8'h3C);
        exp_q.push_back(8'hC3);
        spi_sel = 1'b0;
        tick(3);
        pulse(CMD_LED_HI, 8'hC3);
        tick(20);
        chk("reply_held_busy", {24'h0, reply_data}, 32'h3C);
        chk("led_c33c", {16'h0, led_out}, 32'hC33C);
        spi_sel = 1'b1;
        tick(10);
        chk("reply_after_idle", {24'h0, reply_data}, 32'hC3);

        // 3: blink with period 2 ticks of 4 clocks
        send(CMD_LED_LO, 8'hFF, 8'hFF);
        send(CMD_LED_HI, 8'hFF, 8'hFF);
        chk("led_ffff", {16'h0, led_out}, 32'hFFFF);
        exp_q.push_back(8'h02);
        spi_sel = 1'b0;
        tick(3);
        comm_adr   = CMD_BLINK_CFG;
        comm_data  = 8'h02;
        comm_ready = 1'b1;
        wait_exec(ok);
        chk("blink_exec_seen", {31'h0, ok}, 32'h1);
        @(posedge clk);
        n = 0;
        while (n < 40) begin
            @(posedge clk); n++; #1;
            if (led_out == 16'h0000) break;
        end
        chk("blink_first_toggle_clks", n, 8);
        n = 0;
        while (n < 40) begin
            @(posedge clk); n++; #1;
            if (led_out == 16'hFFFF) break;
        end
        chk("blink_second_toggle_clks", n, 8);
        n = 0;
        while (n < 40) begin
            @(posedge clk); n++; #1;
            if (led_out == 16'h0000) break;
        end
        chk("blink_third_toggle_clks", n, 8);
        comm_ready = 1'b0;
        tick(2);
        spi_sel = 1'b1;
        tick(10);
        send(CMD_BLINK_CFG, 8'h00, 8'h00);
        chk("blink_off_a", {16'h0, led_out}, 32'hFFFF);
        tick(5);
        chk("blink_off_b", {16'h0, led_out}, 32'hFFFF);

        // 4: key latch and clear-on-read
        key_state = 8'h09; tick(4);
        key_state = 8'h00; tick(4);
        send(CMD_KEY_READ, 8'h00, 8'h09);
        send(CMD_KEY_READ, 8'h00, 8'h00);
        key_state = 8'h08; tick(4);
        key_state = 8'h00; tick(4);
        exp_q.push_back(8'h08);
        spi_sel = 1'b0;
        tick(3);
        pulse(CMD_KEY_READ, 8'h00);
        spi_sel = 1'b1;
        tick(1);
        key_state = 8'h08;
        tick(10);
        key_state = 8'h00;
        tick(4);
        send(CMD_KEY_READ, 8'h00, 8'h08);
        send(CMD_KEY_READ, 8'h00, 8'h00);

        // 5: overrun - second strobe while waiting for bus idle
        exp_q.push_back(8'h11);
        spi_sel = 1'b0;
        tick(3);
        pulse(CMD_VERSION, 8'h00);
        tick(2);
        pulse(CMD_LED_LO, 8'hAA);
        spi_sel = 1'b1;
        tick(10);
        chk("overrun_cmd_dropped", {16'h0, led_out}, 32'hFFFF);
        send(CMD_STATUS, 8'h00, 8'hA1);
        send(CMD_STATUS, 8'h00, 8'h26);

        // 6: soft reset, valid and invalid key
        sr_before = sr_cnt;
        send(CMD_SOFT_RESET, 8'hA5, 8'h01);
        chk("soft_rst_pulse_clks", sr_cnt - sr_before, 1);
        chk("soft_rst_led", {16'h0, led_out}, 32'h0);
        send(CMD_LED_LO, 8'h0F, 8'h0F);
        sr_before = sr_cnt;
        send(CMD_SOFT_RESET, 8'h5A, 8'h00);
        chk("soft_rst_bad_key_pulse", sr_cnt - sr_before, 0);
        chk("soft_rst_bad_key_led", {16'h0, led_out}, 32'h000F);

        // rst_n asserted while a command is in EXEC
        send(CMD_LED_HI, 8'hF0, 8'hF0);
        chk("led_f00f", {16'h0, led_out}, 32'hF00F);
        spi_sel = 1'b0;
        tick(3);
        comm_adr   = CMD_LED_HI;
        comm_data  = 8'h77;
        comm_ready = 1'b1;
        wait_exec(ok);
        chk("exec_seen_for_reset", {31'h0, ok}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_reply", {24'h0, reply_data}, 32'h0);
        chk("mid_rst_led", {16'h0, led_out}, 32'h0);
        chk("mid_rst_soft", {31'h0, soft_rst}, 32'h0);
        comm_ready = 1'b0;
        tick(3);
        rst_n = 1'b1;
        spi_sel = 1'b1;
        tick(10);
        chk("after_rst_led", {16'h0, led_out}, 32'h0);
        exp_q.push_back(8'h00);

        // Final transaction drains the last expectation
        spi_sel = 1'b0;
        tick(2);
        spi_sel = 1'b1;
        tick(2);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
